// File: rtl/nx_fifo_wr_arb_pkg.sv
// Shared types and helpers for the nx_fifo write-port round-robin arbiter.
package nx_fifo_arb_pkg;

   typedef enum logic {
      ARB  = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   // Next round-robin position; n need not be a power of two.
   function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
      return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
   endfunction

endpackage

// File: rtl/nx_fifo_wr_arb_if.sv
// Producer beats plus the nx_fifo write port, shared between the arbiter and its environment.
interface nx_fifo_wr_arb_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 106
);
   localparam int ID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_eop;
   logic [N_REQ*WIDTH-1:0] req_data;
   logic [N_REQ-1:0]       req_ready;
   logic                   fifo_full;
   logic                   fifo_wen;
   logic [WIDTH-1:0]       fifo_wdata;
   logic [ID_W-1:0]        grant_id;
   logic                   locked;

   // Environment side: producers and the fifo full flag.
   modport master (
      output req_valid, req_eop, req_data, fifo_full,
      input  req_ready, fifo_wen, fifo_wdata, grant_id, locked
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_eop, req_data, fifo_full,
      output req_ready, fifo_wen, fifo_wdata, grant_id, locked
   );
endinterface

// File: rtl/nx_fifo_wr_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after base, wrapping mod N.
module nx_rr_pick #(
   parameter int  N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] base,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   localparam int PW = IW + 1;

   logic [PW-1:0] pos_s;
   logic          hit_s;

   // Walk positions base, base+1, ... and latch the first requester.
   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      pos_s  = '0;
      hit_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos_s = {1'b0, base} + PW'(k);
         pos_s = (pos_s >= PW'(N)) ? (pos_s - PW'(N)) : pos_s;
         hit_s = !any && req[pos_s[IW-1:0]];
         onehot[pos_s[IW-1:0]] = onehot[pos_s[IW-1:0]] | hit_s;
         idx   = hit_s ? pos_s[IW-1:0] : idx;
         any   = any | hit_s;
      end
   end

endmodule

// File: rtl/nx_fifo_wr_arb.sv
// Round-robin arbiter sharing one nx_fifo write port between N_REQ producers,
// optionally holding the grant until the packet's eop beat is written.
module nx_fifo_wr_arb_chk #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 106
) (
   input logic                   clk,
   input logic                   rst_n,
   input logic [N_REQ-1:0]       req_valid,
   input logic [N_REQ-1:0]       req_eop,
   input logic [N_REQ*WIDTH-1:0] req_data,
   input logic [N_REQ-1:0]       req_ready
);
   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready))
      else $error("req_ready has more than one bit set");

   for (genvar i = 0; i < N_REQ; i++) begin : g_stable
      a_hold: assert property (@(posedge clk) disable iff (!rst_n)
         (req_valid[i] && !req_ready[i]) |=>
            (req_valid[i] && $stable(req_eop[i]) && $stable(req_data[i*WIDTH +: WIDTH])))
         else $error("producer %0d changed a pending beat", i);
   end
endmodule

module nx_fifo_wr_arb
   import nx_fifo_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int WIDTH       = 106,
   parameter int LOCK_ON_EOP = 1
) (
   input logic               clk,
   input logic               rst_n,
   input logic               clear,
   nx_fifo_wr_arb_if.slave   bus
);
   localparam int        ID_W    = $clog2(N_REQ);
   localparam bit        LOCK_EN = (LOCK_ON_EOP != 0);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   arb_state_e        state_r;
   logic [ID_W-1:0]   owner_r;
   logic [ID_W-1:0]   rr_ptr_r;

   logic [N_REQ-1:0]  pick_onehot_s;
   logic [ID_W-1:0]   pick_idx_s;
   logic              pick_any_s;
   logic [ID_W-1:0]   sel_s;
   logic              wen_s;
   logic [N_REQ-1:0]  ready_s;
   logic              open_s;
   logic              eop_s;

   nx_rr_pick #(.N(N_REQ)) u_pick (
      .req    (bus.req_valid),
      .base   (rr_ptr_r),
      .onehot (pick_onehot_s),
      .idx    (pick_idx_s),
      .any    (pick_any_s)
   );

   // Reset and clear win over any accept in the same cycle, as does a full fifo.
   assign open_s = rst_n & ~clear & ~bus.fifo_full;

   // Grant decode: picker result in ARB, fixed owner while a packet is in flight.
   always_comb begin
      sel_s   = pick_idx_s;
      wen_s   = 1'b0;
      ready_s = '0;
      case (state_r)
         ARB: begin
            sel_s   = pick_idx_s;
            wen_s   = pick_any_s & open_s;
            ready_s = open_s ? pick_onehot_s : '0;
         end
         LOCK: begin
            sel_s   = owner_r;
            wen_s   = bus.req_valid[owner_r] & open_s;
            ready_s = open_s ? (ONE_HOT0 << owner_r) : '0;
         end
         default: begin
            sel_s   = pick_idx_s;
            wen_s   = 1'b0;
            ready_s = '0;
         end
      endcase
   end

   assign eop_s          = bus.req_eop[sel_s];
   assign bus.fifo_wen   = wen_s;
   assign bus.req_ready  = ready_s;
   assign bus.fifo_wdata = wen_s ? bus.req_data[int'(sel_s)*WIDTH +: WIDTH] : '0;
   assign bus.grant_id   = sel_s;
   assign bus.locked     = LOCK_EN && (state_r == LOCK);

   // Arbitration state: advances only on an accepted beat.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state_r  <= ARB;
         owner_r  <= '0;
         rr_ptr_r <= '0;
      end else if (wen_s) begin
         case (state_r)
            ARB: begin
               if (LOCK_EN && !eop_s) begin
                  state_r <= LOCK;
                  owner_r <= sel_s;
               end else begin
                  rr_ptr_r <= ID_W'(rr_next(32'(sel_s), 32'(N_REQ)));
               end
            end
            LOCK: begin
               if (eop_s) begin
                  state_r  <= ARB;
                  rr_ptr_r <= ID_W'(rr_next(32'(owner_r), 32'(N_REQ)));
               end else begin
                  state_r <= LOCK;
               end
            end
            default: state_r <= ARB;
         endcase
      end
   end

   nx_fifo_wr_arb_chk #(.N_REQ(N_REQ), .WIDTH(WIDTH)) u_chk (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (bus.req_valid),
      .req_eop   (bus.req_eop),
      .req_data  (bus.req_data),
      .req_ready (bus.req_ready)
   );

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// Randomized scoreboard bench for nx_fifo_wr_arb, plus a short directed run with LOCK_ON_EOP=0.
module tb_nx_fifo_wr_arb;
   localparam int N  = 4;
   localparam int W  = 106;
   localparam int N2 = 3;
   localparam int W2 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, clear, rst_n2, clear2;

   nx_fifo_wr_arb_if #(.N_REQ(N),  .WIDTH(W))  bus  ();
   nx_fifo_wr_arb_if #(.N_REQ(N2), .WIDTH(W2)) bus2 ();

   nx_fifo_wr_arb #(.N_REQ(N), .WIDTH(W), .LOCK_ON_EOP(1)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus)
   );
   nx_fifo_wr_arb #(.N_REQ(N2), .WIDTH(W2), .LOCK_ON_EOP(0)) dut2 (
      .clk(clk), .rst_n(rst_n2), .clear(clear2), .bus(bus2)
   );

   typedef struct {
      int           id;
      logic [W-1:0] data;
   } beat_t;

   beat_t sb_q[$];
   int    checks = 0;
   int    errors = 0;

   // Producer models
   bit           p_valid[N];
   bit           p_eop[N];
   logic [W-1:0] p_data[N];
   int           p_left[N];
   bit           acc[N];
   int           seq = 0;

   // Reference arbiter model
   bit m_lock  = 1'b0;
   int m_owner = 0;
   int m_ptr   = 0;

   bit           exp_wen    = 1'b0;
   bit           exp_locked = 1'b0;
   logic [N-1:0] exp_ready  = '0;
   int           exp_owner  = 0;
   bit           mon_en     = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit rstv, input bit clr, input bit full);
      bit    found;
      int    w;
      int    c;
      beat_t b;
      found      = 1'b0;
      w          = 0;
      exp_locked = m_lock;
      exp_owner  = m_owner;
      exp_wen    = 1'b0;
      exp_ready  = '0;
      for (int i = 0; i < N; i++) acc[i] = 1'b0;
      if (!rstv || clr) begin
         m_lock  = 1'b0;
         m_ptr   = 0;
         m_owner = 0;
      end else if (!full) begin
         if (m_lock) begin
            exp_ready[m_owner] = 1'b1;
            if (p_valid[m_owner]) begin
               found = 1'b1;
               w     = m_owner;
            end
         end else begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (!found && p_valid[c]) begin
                  found = 1'b1;
                  w     = c;
               end
            end
            if (found) exp_ready[w] = 1'b1;
         end
         if (found) begin
            exp_wen = 1'b1;
            acc[w]  = 1'b1;
            b.id    = w;
            b.data  = p_data[w];
            sb_q.push_back(b);
            if (m_lock) begin
               if (p_eop[w]) begin
                  m_lock = 1'b0;
                  m_ptr  = (w + 1) % N;
               end
            end else if (!p_eop[w]) begin
               m_lock  = 1'b1;
               m_owner = w;
            end else begin
               m_ptr = (w + 1) % N;
            end
         end
      end
   endtask

   // One cycle: retire accepted beats, offer new ones, drive the DUT, predict its response.
   task automatic step(input bit rstv, input bit clr, input bit full, input int vprob, input int maxlen);
      logic [127:0] r;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) p_valid[i] = 1'b0;
         if (!p_valid[i] && ($urandom_range(99) < 32'(vprob))) begin
            if (p_left[i] == 0) p_left[i] = int'($urandom_range(32'(maxlen), 1));
            p_left[i]--;
            p_valid[i] = 1'b1;
            p_eop[i]   = (p_left[i] == 0);
            seq++;
            r          = {$urandom, $urandom, $urandom, 32'(seq)};
            p_data[i]  = r[W-1:0];
         end
      end
      rst_n         = rstv;
      clear         = clr;
      bus.fifo_full = full;
      for (int i = 0; i < N; i++) begin
         bus.req_valid[i]         = p_valid[i];
         bus.req_eop[i]           = p_eop[i];
         bus.req_data[i*W +: W]   = p_data[i];
      end
      model(rstv, clr, full);
      mon_en = 1'b1;
   endtask

   // Scoreboard monitor: compares every cycle's outputs and pops on each write.
   always @(negedge clk) begin
      beat_t e;
      if (mon_en) begin
         check("fifo_wen", 128'(bus.fifo_wen), 128'(exp_wen));
         check("req_ready", 128'(bus.req_ready), 128'(exp_ready));
         check("locked", 128'(bus.locked), 128'(exp_locked));
         if (exp_locked) check("grant_id_owner", 128'(bus.grant_id), 128'(exp_owner));
         if (bus.fifo_wen) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got data %0h expected no write", bus.fifo_wdata);
            end else begin
               e = sb_q.pop_front();
               check("wdata", 128'(bus.fifo_wdata), 128'(e.data));
               check("grant_id", 128'(bus.grant_id), 128'(e.id));
            end
         end else begin
            check("wdata_idle", 128'(bus.fifo_wdata), 128'd0);
            if (exp_wen && sb_q.size() > 0) e = sb_q.pop_front();
         end
      end
   end

   initial begin
      logic [7:0] d0, d1, ew;
      int         eid;

      rst_n = 1'b0; clear = 1'b0;
      bus.fifo_full = 1'b0; bus.req_valid = '0; bus.req_eop = '0; bus.req_data = '0;
      for (int i = 0; i < N; i++) begin
         p_valid[i] = 1'b0; p_eop[i] = 1'b0; p_data[i] = '0; p_left[i] = 0; acc[i] = 1'b0;
      end
      rst_n2 = 1'b0; clear2 = 1'b0;
      d0 = 8'h10; d1 = 8'h20;
      bus2.fifo_full = 1'b0; bus2.req_valid = 3'b011; bus2.req_eop = 3'b000;
      bus2.req_data  = {8'h00, d1, d0};

      // Reset with every producer valid, then single-beat rotation
      for (int c = 0; c < 3; c++)  step(1'b0, 1'b0, 1'b0, 100, 1);
      for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 1'b0, 100, 1);
      // Multi-beat packets with a 5-cycle full window
      for (int c = 0; c < 6; c++)  step(1'b1, 1'b0, 1'b0, 100, 4);
      for (int c = 0; c < 5; c++)  step(1'b1, 1'b0, 1'b1, 100, 4);
      for (int c = 0; c < 6; c++)  step(1'b1, 1'b0, 1'b0, 100, 4);
      // Random traffic with bubbles, backpressure, clears and resets
      for (int c = 0; c < 800; c++)
         step(($urandom_range(99) != 0), ($urandom_range(49) == 0), ($urandom_range(4) == 0), 60, 4);
      @(negedge clk);
      #1 mon_en = 1'b0;
      check("scoreboard_empty", 128'(sb_q.size()), 128'd0);

      // LOCK_ON_EOP=0 with N=3: multi-beat req0 and req1 alternate
      @(posedge clk);
      #1;
      @(negedge clk);
      check("n_reset_wen", 128'(bus2.fifo_wen), 128'd0);
      check("n_reset_ready", 128'(bus2.req_ready), 128'd0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         rst_n2 = 1'b1;
         bus2.req_data = {8'h00, d1, d0};
         eid = k % 2;
         ew  = (eid == 0) ? 8'(16 + k / 2) : 8'(32 + k / 2);
         @(negedge clk);
         check("n_wen", 128'(bus2.fifo_wen), 128'd1);
         check("n_grant", 128'(bus2.grant_id), 128'(eid));
         check("n_wdata", 128'(bus2.fifo_wdata), 128'(ew));
         check("n_locked", 128'(bus2.locked), 128'd0);
         if (eid == 0) d0 = d0 + 8'd1;
         else          d1 = d1 + 8'd1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
